chip_cap_ctrl: RTL and testbench
================================

Name: chip_cap_ctrl

Overview:
Capture sequencer that sits downstream of the chip path selector. It drives that block's buf_rdy and accepts its gated output (d1_data/d1_vld/sel_path) into a frame buffer. It sequences arm -> capture -> host readout -> holdoff, and reports frame status to the host register interface.

Parameters:
AW, 12, frame buffer address width (4096 words; covers the 4000-sample chip window)
HW, 16, holdoff counter width
FCW, 16, frame counter width

Ports:
clk_sys  in  1  system clock
rst_n  in  1  async active-low reset
d1_data  in  16  gated sample from chip path
d1_vld  in  1  sample valid from chip path
sel_path  in  7  selected channel index from chip path
buf_rdy  out  1  accept enable returned to chip path
wr_en  out  1  frame buffer write strobe
wr_addr  out  AW  frame buffer write address
wr_data  out  16  frame buffer write data
cfg_arm  in  1  pulse: arm capture
cfg_stop  in  1  pulse: abort to IDLE
cfg_auto  in  1  level: re-arm automatically after holdoff
cfg_len  in  AW  samples per frame; 0 is treated as 1; must equal chip window length
cfg_holdoff  in  HW  clk_sys cycles between readout done and re-arm
rd_done  in  1  pulse from host reader: frame consumed
frame_rdy  out  1  level: frame complete, awaiting readout
irq  out  1  one-cycle pulse on frame complete
cap_path  out  7  sel_path latched at first accepted sample
cap_len  out  AW  number of samples written in last frame
frame_cnt  out  FCW  completed frames, wraps
busy  out  1  state != IDLE
cap_ts  out  32  trigger timestamp (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; address and counters 0.
- FSM states: IDLE, ARM, CAP, DONE, HOLD.
- Accept condition: acc = buf_rdy & d1_vld.
- buf_rdy is registered and decoded from the next state: 1 only when next state is ARM or CAP. It therefore drops on the same edge the FSM leaves CAP, and no sample is accepted after the last one.
- IDLE: on cfg_arm -> ARM. All other inputs are ignored.
- ARM: on acc, write the sample at address 0, latch cap_path <= sel_path, and go to CAP. If cfg_len <= 1, go directly to DONE instead.
- CAP: each acc writes at addr+1. When the accepted sample is number cfg_len (addr == cfg_len-1), go to DONE.
- Gaps in d1_vld inside CAP are legal. The FSM waits indefinitely; there is no timeout.
- Write latency: wr_en/wr_addr/wr_data are registered copies of acc/address/d1_data, one cycle after acceptance.
- Entry to DONE:
  - irq pulses one cycle.
  - frame_rdy <= 1.
  - cap_len <= samples written.
  - frame_cnt increments, wrapping at 2^FCW.
- DONE: on rd_done, frame_rdy <= 0, load the holdoff counter with cfg_holdoff, and go to HOLD. rd_done in any other state is ignored.
- HOLD: decrement each cycle. At 0 (or immediately if cfg_holdoff == 0), go to ARM if cfg_auto, else to IDLE.
- cfg_stop has priority over everything in every state:
  - next state IDLE, buf_rdy 0 next cycle, frame_rdy 0.
  - A partial frame does not bump frame_cnt or raise irq.
  - An acc in the same cycle as cfg_stop is still written.
- cfg_arm while not in IDLE is ignored. cfg_arm and cfg_stop in the same cycle: stop wins.
- cfg_len and cfg_holdoff are sampled on entry to ARM and HOLD respectively; changes mid-frame have no effect until the next frame.
- Async reset mid-capture returns to IDLE with buf_rdy 0 immediately. The chip path window may still be frozen and will resume on the next arm.

Optional Feature:
- Macro CHIP_CAP_TS_EN.
- Defined: a free-running 32-bit clk_sys cycle counter (reset 0, wraps). It is latched into cap_ts on the ARM->CAP/DONE transition, i.e. the first accepted sample. cap_ts holds until the next first-accept.
- Undefined: no counter is built and cap_ts is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0, ST_ARM=1, ST_CAP=2, ST_DONE=3, ST_HOLD=4 (3 bits)
  - default frame length 4000
  - AW/HW defaults
- One natural sub-module: chip_cap_hold, the loadable holdoff down-counter with zero/expire flag. The FSM, address counter and write register stay in the top.

Test Plan:
- cfg_len=10, cfg_arm, then 10 consecutive d1_vld with data 0x100..0x109 and sel_path=3 -> wr_addr 0..9 carry the data one cycle late; irq once; frame_rdy=1; cap_path=3; cap_len=10; frame_cnt=1; buf_rdy=0 from the cycle after the 10th accept.
- Same frame with d1_vld toggling every other cycle -> exactly 10 writes, contiguous addresses, DONE after the 10th.
- In DONE, rd_done with cfg_holdoff=5 and cfg_auto=1 -> frame_rdy drops next cycle; buf_rdy reasserts exactly 6 cycles after rd_done (5 HOLD cycles plus the ARM register); frame_cnt=2 after the next frame. With cfg_auto=0 -> IDLE, busy=0.
- cfg_stop after 4 accepted samples -> IDLE next cycle, buf_rdy=0, no irq, frame_cnt unchanged, 4 writes only. A following arm restarts at addr 0.
- cfg_len=0 and cfg_len=1 -> single write at addr 0, then DONE; cfg_arm during CAP ignored; cfg_arm+cfg_stop together in IDLE -> stays IDLE.
- With CHIP_CAP_TS_EN: arm at cycle 100, first d1_vld at cycle 120 -> cap_ts=120. Without the macro -> cap_ts=0 always.

Source files
------------

// File: rtl/chip_cap_pkg.sv
// Shared definitions for the chip capture sequencer: state encoding and size defaults.
package chip_cap_pkg;

    localparam int AW_DEF        = 12;
    localparam int HW_DEF        = 16;
    localparam int FCW_DEF       = 16;
    localparam int FRAME_LEN_DEF = 4000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_CAP  = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } cap_state_e;

endpackage

// File: rtl/chip_cap_hold.sv
// Loadable holdoff down-counter; `last` marks the final holdoff cycle, `zero` an idle counter.
module chip_cap_hold #(
    parameter int HW = 16
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          load,
    input  logic [HW-1:0] load_val,
    input  logic          dec,
    output logic          zero,
    output logic          last
);

    logic [HW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - HW'(1);
    end

    assign zero = (cnt == '0);
    assign last = (cnt == HW'(1));

endmodule

// File: rtl/chip_cap_ctrl.sv
// Capture sequencer: arm -> capture -> host readout -> holdoff, writing accepted samples to a frame buffer.
// Optional trigger timestamp is built when CHIP_CAP_TS_EN is defined; otherwise cap_ts is 0.
module chip_cap_ctrl
    import chip_cap_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int HW  = HW_DEF,
    parameter int FCW = FCW_DEF
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic [15:0]    d1_data,
    input  logic           d1_vld,
    input  logic [6:0]     sel_path,
    output logic           buf_rdy,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [15:0]    wr_data,
    input  logic           cfg_arm,
    input  logic           cfg_stop,
    input  logic           cfg_auto,
    input  logic [AW-1:0]  cfg_len,
    input  logic [HW-1:0]  cfg_holdoff,
    input  logic           rd_done,
    output logic           frame_rdy,
    output logic           irq,
    output logic [6:0]     cap_path,
    output logic [AW-1:0]  cap_len,
    output logic [FCW-1:0] frame_cnt,
    output logic           busy,
    output logic [31:0]    cap_ts
);

    cap_state_e    state, nxt;
    logic [AW-1:0] addr;
    logic [AW-1:0] len_q;
    logic          acc, first_acc;
    logic          start_arm, to_done, hold_load;
    logic          hold_zero, hold_last;

    assign acc       = buf_rdy & d1_vld;
    assign first_acc = acc && (state == ST_ARM);
    assign busy      = (state != ST_IDLE);

    chip_cap_hold #(.HW(HW)) u_hold (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (cfg_holdoff),
        .dec      (state == ST_HOLD),
        .zero     (hold_zero),
        .last     (hold_last)
    );

    always_comb begin
        nxt       = state;
        start_arm = 1'b0;
        to_done   = 1'b0;
        hold_load = 1'b0;
        if (cfg_stop) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cfg_arm) begin
                    nxt       = ST_ARM;
                    start_arm = 1'b1;
                end
                ST_ARM: if (acc) begin
                    if (len_q == AW'(1)) begin
                        nxt     = ST_DONE;
                        to_done = 1'b1;
                    end else begin
                        nxt = ST_CAP;
                    end
                end
                ST_CAP: if (acc && (addr == len_q - AW'(1))) begin
                    nxt     = ST_DONE;
                    to_done = 1'b1;
                end
                ST_DONE: if (rd_done) begin
                    // A zero holdoff skips HOLD so re-arm follows readout directly
                    if (cfg_holdoff == '0) begin
                        nxt       = cfg_auto ? ST_ARM : ST_IDLE;
                        start_arm = cfg_auto;
                    end else begin
                        nxt       = ST_HOLD;
                        hold_load = 1'b1;
                    end
                end
                ST_HOLD: if (hold_last || hold_zero) begin
                    nxt       = cfg_auto ? ST_ARM : ST_IDLE;
                    start_arm = cfg_auto;
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            buf_rdy   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            addr      <= '0;
            len_q     <= '0;
            irq       <= 1'b0;
            frame_rdy <= 1'b0;
            cap_len   <= '0;
            frame_cnt <= '0;
            cap_path  <= '0;
        end else begin
            state   <= nxt;
            buf_rdy <= (nxt == ST_ARM) || (nxt == ST_CAP);
            wr_en   <= acc;
            irq     <= to_done;
            if (acc) begin
                wr_addr <= addr;
                wr_data <= d1_data;
                addr    <= addr + AW'(1);
            end
            if (start_arm) begin
                addr  <= '0;
                len_q <= (cfg_len == '0) ? AW'(1) : cfg_len;
            end
            if (first_acc)
                cap_path <= sel_path;
            if (to_done) begin
                frame_rdy <= 1'b1;
                cap_len   <= addr + AW'(1);
                frame_cnt <= frame_cnt + FCW'(1);
            end
            if (cfg_stop || (state == ST_DONE && rd_done))
                frame_rdy <= 1'b0;
        end
    end

`ifdef CHIP_CAP_TS_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            cap_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (first_acc)
                cap_ts <= ts_cnt;
        end
    end
`else
    assign cap_ts = '0;
`endif

endmodule

// File: tb/tb_chip_cap_ctrl.sv
// Self-checking bench for chip_cap_ctrl: directed frames plus randomized traffic against a frame-level model.
module tb_chip_cap_ctrl;

    localparam int AW = 12, HW = 16, FCW = 16;

    logic           clk_sys = 1'b0;
    logic           rst_n   = 1'b0;
    logic [15:0]    d1_data = '0;
    logic           d1_vld  = 1'b0;
    logic [6:0]     sel_path = '0;
    logic           buf_rdy, wr_en, frame_rdy, irq, busy;
    logic [AW-1:0]  wr_addr, cap_len;
    logic [15:0]    wr_data;
    logic           cfg_arm = 1'b0, cfg_stop = 1'b0, cfg_auto = 1'b0, rd_done = 1'b0;
    logic [AW-1:0]  cfg_len = '0;
    logic [HW-1:0]  cfg_holdoff = '0;
    logic [6:0]     cap_path;
    logic [FCW-1:0] frame_cnt;
    logic [31:0]    cap_ts;

    int n_chk = 0;
    int n_err = 0;

    chip_cap_ctrl #(.AW(AW), .HW(HW), .FCW(FCW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .d1_data(d1_data), .d1_vld(d1_vld),
        .sel_path(sel_path), .buf_rdy(buf_rdy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_auto(cfg_auto),
        .cfg_len(cfg_len), .cfg_holdoff(cfg_holdoff), .rd_done(rd_done),
        .frame_rdy(frame_rdy), .irq(irq), .cap_path(cap_path), .cap_len(cap_len),
        .frame_cnt(frame_cnt), .busy(busy), .cap_ts(cap_ts)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: phase of the capture, samples written so far, holdoff cycles left.
    localparam int P_IDLE = 0, P_WAIT_FIRST = 1, P_CAPTURE = 2, P_READY = 3, P_HOLD = 4;
    int     phase, written, frame_len, hold_left;
    bit     m_buf_rdy, m_wr_en, m_irq, m_frame_rdy;
    int     m_wr_addr, m_wr_data, m_cap_path, m_cap_len, m_frame_cnt;
    longint cycles, m_cap_ts;

    function automatic void start_frame();
        phase     = P_WAIT_FIRST;
        written   = 0;
        frame_len = (cfg_len == 0) ? 1 : int'(cfg_len);
    endfunction

    function automatic void after_readout();
        if (cfg_auto) start_frame();
        else          phase = P_IDLE;
    endfunction

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            phase = P_IDLE; written = 0; frame_len = 1; hold_left = 0;
            m_buf_rdy = 0; m_wr_en = 0; m_irq = 0; m_frame_rdy = 0;
            m_wr_addr = 0; m_wr_data = 0; m_cap_path = 0; m_cap_len = 0;
            m_frame_cnt = 0; cycles = 0; m_cap_ts = 0;
        end else begin
            automatic bit acc = m_buf_rdy && d1_vld;
            automatic int was = phase;
            m_wr_en = acc;
            m_irq   = 0;
            if (acc) begin
                m_wr_addr = written;
                m_wr_data = int'(d1_data);
                written++;
                if (was == P_WAIT_FIRST) begin
                    m_cap_path = int'(sel_path);
                    m_cap_ts   = cycles;
                end
            end
            if (cfg_stop) begin
                phase = P_IDLE;
                m_frame_rdy = 0;
            end else if (was == P_IDLE) begin
                if (cfg_arm) start_frame();
            end else if (was == P_WAIT_FIRST || was == P_CAPTURE) begin
                if (acc && written == frame_len) begin
                    phase = P_READY;
                    m_irq = 1;
                    m_frame_rdy = 1;
                    m_cap_len = written;
                    m_frame_cnt = (m_frame_cnt + 1) % 65536;
                end else if (acc) begin
                    phase = P_CAPTURE;
                end
            end else if (was == P_READY) begin
                if (rd_done) begin
                    m_frame_rdy = 0;
                    if (cfg_holdoff == 0) after_readout();
                    else begin
                        phase = P_HOLD;
                        hold_left = int'(cfg_holdoff);
                    end
                end
            end else begin
                hold_left--;
                if (hold_left == 0) after_readout();
            end
            m_buf_rdy = (phase == P_WAIT_FIRST) || (phase == P_CAPTURE);
            cycles = (cycles + 1) % 64'h1_0000_0000;
        end
    end

    always @(negedge clk_sys) begin
        chk("buf_rdy", buf_rdy, m_buf_rdy);
        chk("wr_en", wr_en, m_wr_en);
        if (m_wr_en) begin
            chk("wr_addr", wr_addr, m_wr_addr);
            chk("wr_data", wr_data, m_wr_data);
        end
        chk("irq", irq, m_irq);
        chk("frame_rdy", frame_rdy, m_frame_rdy);
        chk("cap_path", cap_path, m_cap_path);
        chk("cap_len", cap_len, m_cap_len);
        chk("frame_cnt", frame_cnt, m_frame_cnt);
        chk("busy", busy, phase != P_IDLE);
`ifdef CHIP_CAP_TS_EN
        chk("cap_ts", cap_ts, m_cap_ts);
`else
        chk("cap_ts", cap_ts, 0);
`endif
    end

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic quiet();
        cfg_arm = 0; cfg_stop = 0; rd_done = 0; d1_vld = 0;
    endtask

    initial begin
        int k, nacc;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_buf_rdy", buf_rdy, 0);

        // Frame 1: ten back-to-back samples
        cfg_len = 10; cfg_arm = 1; step(); quiet();
        chk("armed_buf_rdy", buf_rdy, 1);
        for (int i = 0; i < 10; i++) begin
            d1_vld = 1; d1_data = 16'h100 + 16'(i); sel_path = 7'd3;
            step();
        end
        quiet(); sel_path = 7'd5;
        chk("f1_irq", irq, 1);
        chk("f1_frame_rdy", frame_rdy, 1);
        chk("f1_cap_len", cap_len, 10);
        chk("f1_cap_path", cap_path, 3);
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_buf_rdy", buf_rdy, 0);
        chk("f1_last_addr", wr_addr, 9);
        chk("f1_last_data", wr_data, 16'h109);

        // Readout with holdoff 5, auto re-arm
        cfg_holdoff = 5; cfg_auto = 1; rd_done = 1; step(); quiet();
        chk("hold_frame_rdy", frame_rdy, 0);
        k = 1;
        while (!buf_rdy && k < 20) begin step(); k++; end
        chk("holdoff_rearm_cycles", k, 6);

        // Frame 2: valid toggling, extra offers must be refused
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            d1_vld = (c % 2 == 0); d1_data = 16'(16'h200 + c);
            if (buf_rdy && d1_vld) nacc++;
            step();
        end
        quiet();
        chk("f2_accepts", nacc, 10);
        chk("f2_frame_cnt", frame_cnt, 2);
        chk("f2_cap_len", cap_len, 10);

        // Readout without auto re-arm returns to idle
        cfg_auto = 0; rd_done = 1; step(); quiet();
        k = 0;
        while (busy && k < 20) begin step(); k++; end
        chk("noauto_busy", busy, 0);
        chk("noauto_buf_rdy", buf_rdy, 0);

        // Abort after four samples
        cfg_arm = 1; step(); quiet();
        for (int i = 0; i < 4; i++) begin d1_vld = 1; d1_data = 16'(16'h300 + i); step(); end
        quiet(); cfg_stop = 1; step(); quiet();
        chk("stop_busy", busy, 0);
        chk("stop_buf_rdy", buf_rdy, 0);
        chk("stop_frame_cnt", frame_cnt, 2);
        chk("stop_irq", irq, 0);
        cfg_arm = 1; step(); quiet();
        d1_vld = 1; d1_data = 16'hABC; step(); quiet();
        chk("restart_addr", wr_addr, 0);
        chk("restart_data", wr_data, 16'hABC);
        cfg_stop = 1; step(); quiet();

        // Zero length behaves as one sample
        cfg_len = 0; cfg_arm = 1; step(); quiet();
        d1_vld = 1; d1_data = 16'h55; step(); quiet();
        chk("len0_irq", irq, 1);
        chk("len0_cap_len", cap_len, 1);
        chk("len0_frame_cnt", frame_cnt, 3);
        chk("len0_buf_rdy", buf_rdy, 0);
        cfg_stop = 1; step(); quiet();
        cfg_arm = 1; cfg_stop = 1; step(); quiet();
        chk("arm_stop_idle", busy, 0);

        // Randomized traffic, with one asynchronous reset mid-run
        for (int i = 0; i < 15000; i++) begin
            d1_vld      = ($urandom_range(0, 2) != 0);
            d1_data     = 16'($urandom);
            sel_path    = 7'($urandom);
            cfg_arm     = ($urandom_range(0, 9) == 0);
            cfg_stop    = ($urandom_range(0, 299) == 0);
            rd_done     = ($urandom_range(0, 7) == 0);
            cfg_len     = AW'($urandom_range(0, 12));
            cfg_holdoff = HW'($urandom_range(0, 6));
            cfg_auto    = ($urandom_range(0, 3) != 0);
            step();
            if (i == 7000) begin
                #2 rst_n = 1'b0;
                step(); step();
                rst_n = 1'b1;
            end
        end
        quiet();
        step();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
